// File: rtl/multichannel_averager.sv
// multichannel_averager: block averager over CHANNELS parallel sample lanes.
// A block of N samples is summed at full width per lane; on the Nth sample all
// lane results move to the output register together, optionally divided by
// 2^floor(log2(N)). A result that cannot be delivered is dropped and flagged.

module multichannel_averager #(
   parameter int CHANNELS   = 4,
   parameter int DATA_BITS  = 16,
   parameter int COUNT_BITS = 16,
   parameter int SIGNED     = 1,
   localparam int OUT_BITS  = DATA_BITS + COUNT_BITS
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [COUNT_BITS-1:0]          averaging_points,
   input  logic                           shift_en,
   input  logic                           in_valid,
   input  logic [CHANNELS*DATA_BITS-1:0]  in_data,
   output logic [CHANNELS*OUT_BITS-1:0]   out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           overrun,
   output logic                           busy
);

   localparam int SHIFT_W = (COUNT_BITS > 1) ? $clog2(COUNT_BITS) : 1;

   // One-hot encoding leaves spare codes; those recover to IDLE.
   localparam logic [1:0] IDLE  = 2'b01;
   localparam logic [1:0] ACCUM = 2'b10;

   logic [1:0]            state_q, state_d;
   logic [COUNT_BITS-1:0] n_lat_q, count_q, n_eff;
   logic [SHIFT_W-1:0]    shift_q, lane_shift;
   logic                  shift_en_q, lane_shift_en;
   logic                  load, add, complete, clear;
   logic [CHANNELS-1:0][OUT_BITS-1:0] lane_result;

   // Position of the highest set bit, i.e. floor(log2(v)) for v >= 1.
   function automatic logic [SHIFT_W-1:0] floor_log2(input logic [COUNT_BITS-1:0] v);
      floor_log2 = '0;
      for (int i = 0; i < COUNT_BITS; i++)
         if (v[i]) floor_log2 = i[SHIFT_W-1:0];
   endfunction

   assign n_eff = (averaging_points == '0) ? COUNT_BITS'(1) : averaging_points;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: leave IDLE only for multi-sample blocks; return on the Nth sample.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = (in_valid && n_eff != COUNT_BITS'(1)) ? ACCUM : IDLE;
         ACCUM:   state_d = complete ? IDLE : ACCUM;
         default: state_d = IDLE;
      endcase
   end

   // Per-state controls; completion is decided in the same cycle as the last sample.
   always_comb begin
      busy          = (state_q == ACCUM);
      clear         = (state_q != IDLE) && (state_q != ACCUM);
      load          = (state_q == IDLE) && in_valid;
      add           = (state_q == ACCUM) && in_valid;
      complete      = (load && n_eff == COUNT_BITS'(1)) ||
                      (add && (count_q + COUNT_BITS'(1)) == n_lat_q);
      // A block completing from IDLE has N=1, so no shift applies there.
      lane_shift_en = busy ? shift_en_q : 1'b0;
      lane_shift    = busy ? shift_q : '0;
   end

   // Block parameters are frozen at block start; count tracks accepted samples.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         n_lat_q    <= '0;
         count_q    <= '0;
         shift_q    <= '0;
         shift_en_q <= 1'b0;
      end else if (load) begin
         n_lat_q    <= n_eff;
         count_q    <= COUNT_BITS'(1);
         shift_q    <= floor_log2(n_eff);
         shift_en_q <= shift_en;
      end else if (add) begin
         count_q    <= count_q + COUNT_BITS'(1);
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      multichannel_averager_lane #(
         .DATA_BITS  (DATA_BITS),
         .COUNT_BITS (COUNT_BITS),
         .SIGNED     (SIGNED),
         .SHIFT_W    (SHIFT_W)
      ) u_lane (
         .clock    (clock),
         .reset    (reset),
         .clear    (clear),
         .load     (load),
         .add      (add),
         .sample   (in_data[k*DATA_BITS +: DATA_BITS]),
         .shift_en (lane_shift_en),
         .shift    (lane_shift),
         .result   (lane_result[k])
      );
   end

   // Output register: load on completion if free or being drained, else drop and flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (complete) begin
         if (!out_valid || out_ready) begin
            out_data  <= lane_result;
            out_valid <= 1'b1;
         end else begin
            overrun   <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// One channel: extends the sample, accumulates, and forms the (shifted) result
// combinationally from the sum that includes the current sample.
module multichannel_averager_lane #(
   parameter int DATA_BITS  = 16,
   parameter int COUNT_BITS = 16,
   parameter int SIGNED     = 1,
   parameter int SHIFT_W    = 4,
   localparam int OUT_BITS  = DATA_BITS + COUNT_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 load,
   input  logic                 add,
   input  logic [DATA_BITS-1:0] sample,
   input  logic                 shift_en,
   input  logic [SHIFT_W-1:0]   shift,
   output logic [OUT_BITS-1:0]  result
);

   logic [OUT_BITS-1:0]        acc_q, ext, sum;
   logic signed [OUT_BITS-1:0] sum_s;

   // Extend, sum, and scale the running total.
   always_comb begin
      ext = (SIGNED != 0) ? {{COUNT_BITS{sample[DATA_BITS-1]}}, sample}
                          : {{COUNT_BITS{1'b0}}, sample};
      sum    = load ? ext : acc_q + ext;
      sum_s  = sum;
      result = sum;
      if (shift_en) begin
         if (SIGNED != 0) result = sum_s >>> shift;
         else             result = sum >> shift;
      end
   end

   // Accumulator: restart on load, grow on add, cleared on reset or bad state.
   always_ff @(posedge clock) begin
      if (reset || clear)  acc_q <= '0;
      else if (load || add) acc_q <= sum;
   end

endmodule

// File: tb/tb_multichannel_averager.sv
// Scoreboard bench for multichannel_averager: a signed 4-channel instance and
// an unsigned 2-channel instance share clock and reset.

module tb_multichannel_averager;

   localparam int CH  = 4;
   localparam int UCH = 2;
   localparam int DB  = 16;
   localparam int CB  = 16;
   localparam int OB  = DB + CB;

   logic clock = 1'b0;
   logic reset;

   logic [CB-1:0]     averaging_points;
   logic              shift_en, in_valid, out_ready;
   logic [CH*DB-1:0]  in_data;
   logic [CH*OB-1:0]  out_data;
   logic              out_valid, overrun, busy;

   logic [CB-1:0]     u_averaging_points;
   logic              u_shift_en, u_in_valid, u_out_ready;
   logic [UCH*DB-1:0] u_in_data;
   logic [UCH*OB-1:0] u_out_data;
   logic              u_out_valid, u_overrun, u_busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [CH*OB-1:0]  exp_q[$];
   logic [UCH*OB-1:0] u_exp_q[$];
   logic [CH*OB-1:0]  mon_exp;

   multichannel_averager #(.CHANNELS(CH), .DATA_BITS(DB), .COUNT_BITS(CB), .SIGNED(1)) dut (
      .clock(clock), .reset(reset), .averaging_points(averaging_points), .shift_en(shift_en),
      .in_valid(in_valid), .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .overrun(overrun), .busy(busy));

   multichannel_averager #(.CHANNELS(UCH), .DATA_BITS(DB), .COUNT_BITS(CB), .SIGNED(0)) dut_u (
      .clock(clock), .reset(reset), .averaging_points(u_averaging_points), .shift_en(u_shift_en),
      .in_valid(u_in_valid), .in_data(u_in_data), .out_data(u_out_data), .out_valid(u_out_valid),
      .out_ready(u_out_ready), .overrun(u_overrun), .busy(u_busy));

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [CH*DB-1:0] pk_in(input int a, input int b, input int c, input int d);
      logic [CH*DB-1:0] v;
      v[0*DB +: DB] = a[DB-1:0];
      v[1*DB +: DB] = b[DB-1:0];
      v[2*DB +: DB] = c[DB-1:0];
      v[3*DB +: DB] = d[DB-1:0];
      return v;
   endfunction

   function automatic logic [CH*OB-1:0] pk_out(input int a, input int b, input int c, input int d);
      logic [CH*OB-1:0] v;
      v[0*OB +: OB] = a[OB-1:0];
      v[1*OB +: OB] = b[OB-1:0];
      v[2*OB +: OB] = c[OB-1:0];
      v[3*OB +: OB] = d[OB-1:0];
      return v;
   endfunction

   // Every accepted result of the signed instance is matched against the queue.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_extra: got %h, required no result", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) $display("FAIL scoreboard_data: got %h, required %h", out_data, mon_exp);
            else n_pass++;
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0; u_in_valid = 1'b0;
      out_ready = 1'b0; u_out_ready = 1'b0;
      averaging_points = '0; u_averaging_points = '0;
      shift_en = 1'b0; u_shift_en = 1'b0;
      in_data = '0; u_in_data = '0;
      repeat (2) tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h, required 0", out_data); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b, required 0", overrun); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
      n_checks++; if (u_out_valid !== 1'b0) $display("FAIL reset_u_out_valid: got %b, required 0", u_out_valid); else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_signed_mean();
      int s0[4] = '{-3, -5, 7, 1};
      int s2[4] = '{1, 2, 3, 5};
      int s3[4] = '{-1, -2, -2, -2};
      out_ready = 1'b1; averaging_points = 16'd4; shift_en = 1'b1;
      exp_q.push_back(pk_out(0, 100, 2, -2));
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            n_checks++; if (out_valid !== 1'b0) $display("FAIL mean_early: got %b, required 0", out_valid); else n_pass++;
         end
         in_valid = 1'b1; in_data = pk_in(s0[i], 100, s2[i], s3[i]);
         tick();
         if (i == 0) begin
            n_checks++; if (busy !== 1'b1) $display("FAIL mean_busy: got %b, required 1", busy); else n_pass++;
         end
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL mean_valid_rise: got %b, required 1", out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mean_idle: got %b, required 0", busy); else n_pass++;
      tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL mean_single_pulse: got %b, required 0", out_valid); else n_pass++;
   endtask

   task automatic test_shift_non_pow2();
      out_ready = 1'b1; averaging_points = 16'd5; shift_en = 1'b1;
      exp_q.push_back(pk_out(12, -13, 3, 0));
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = pk_in(10, -10, 3, 0);
         tick();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL n5_valid: got %b, required 1", out_valid); else n_pass++;
      tick();
   endtask

   task automatic test_unsigned_hold();
      logic [UCH*OB-1:0] uexp;
      logic [OB-1:0] c0, c1;
      c0 = 32'h0001_7FFD; c1 = 32'h0002_FFFD;
      u_exp_q.push_back({c1, c0});
      u_out_ready = 1'b0; u_averaging_points = 16'd3; u_shift_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         u_in_valid = 1'b1; u_in_data = {16'hFFFF, 16'h7FFF};
         tick();
      end
      u_in_valid = 1'b0;
      uexp = u_exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (u_out_valid !== 1'b1) $display("FAIL unsigned_hold_valid: got %b, required 1", u_out_valid); else n_pass++;
         n_checks++; if (u_out_data !== uexp) $display("FAIL unsigned_hold_data: got %h, required %h", u_out_data, uexp); else n_pass++;
         tick();
      end
      u_out_ready = 1'b1;
      tick();
      u_out_ready = 1'b0;
      n_checks++; if (u_out_valid !== 1'b0) $display("FAIL unsigned_consume: got %b, required 0", u_out_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; averaging_points = 16'd1; shift_en = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         in_valid = 1'b1; in_data = pk_in(k, -k, k * 100, 0);
         exp_q.push_back(pk_out(k, -k, k * 100, 0));
         tick();
         n_checks++; if (out_valid !== 1'b1) $display("FAIL n1_valid_%0d: got %b, required 1", k, out_valid); else n_pass++;
         n_checks++; if (busy !== 1'b0) $display("FAIL n1_busy_%0d: got %b, required 0", k, busy); else n_pass++;
      end
      in_valid = 1'b0;
      tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL n1_drain: got %b, required 0", out_valid); else n_pass++;
   endtask

   task automatic test_overrun();
      int s0[4] = '{10, 20, 30, 40};
      int s1[4] = '{-1, -2, -3, -4};
      logic [CH*OB-1:0] first;
      first = pk_out(30, -3, 0, 0);
      exp_q.push_back(first);
      out_ready = 1'b0; averaging_points = 16'd2; shift_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = pk_in(s0[i], s1[i], 0, 0);
         tick();
         if (i == 1) begin
            n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_early: got %b, required 0", overrun); else n_pass++;
         end
      end
      in_valid = 1'b0;
      n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b, required 1", overrun); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL ovr_valid: got %b, required 1", out_valid); else n_pass++;
      n_checks++; if (out_data !== first) $display("FAIL ovr_held: got %h, required %h", out_data, first); else n_pass++;
      out_ready = 1'b1;
      tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL ovr_consume: got %b, required 0", out_valid); else n_pass++;
      n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b, required 1", overrun); else n_pass++;
   endtask

   task automatic test_reset_midblock();
      out_ready = 1'b1; averaging_points = 16'd8; shift_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = pk_in(100, 100, 100, 100);
         tick();
      end
      in_valid = 1'b0;
      n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy_before: got %b, required 1", busy); else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy_after: got %b, required 0", busy); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b, required 0", overrun); else n_pass++;
      exp_q.push_back(pk_out(2, -2, 7, 0));
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_n_frozen: got %b, required 0", out_valid); else n_pass++;
         end
         in_valid = 1'b1; in_data = pk_in(2, -2, 7, 0);
         tick();
         if (i == 0) begin
            averaging_points = 16'd2; shift_en = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL rst_result_valid: got %b, required 1", out_valid); else n_pass++;
      tick();
   endtask

   task automatic test_n_zero();
      out_ready = 1'b1; averaging_points = 16'd0; shift_en = 1'b1;
      exp_q.push_back(pk_out(9, -9, 0, 1));
      in_valid = 1'b1; in_data = pk_in(9, -9, 0, 1);
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL n0_valid: got %b, required 1", out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL n0_busy: got %b, required 0", busy); else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_signed_mean();
      test_shift_non_pow2();
      test_unsigned_hold();
      test_back_to_back();
      test_overrun();
      test_reset_midblock();
      test_n_zero();
      repeat (2) tick();
      n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
